// File: rtl/puzzle_pkg.sv
// Shared constants, FSM state type and helpers for the puzzle-set index selector.
package puzzle_pkg;

  localparam int unsigned IDX_W    = 4;
  localparam int unsigned NUM_SETS = 16;
  localparam int unsigned LFSR_W   = 8;
  localparam int unsigned CNT_W    = 5;

  // Feedback taps: bits 7, 5, 4, 3 (maximal-length 8-bit Fibonacci LFSR).
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    PRESENT
  } state_e;

  // Number of set bits in a 16-bit mask; used to size a full deck.
  function automatic logic [CNT_W-1:0] popcount16(input logic [NUM_SETS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_SETS; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/puzzle_lfsr.sv
// Free-running 8-bit Fibonacci LFSR with a zero-seed guard.
// Ports:
//   clk, rst_n : clock, async active-low reset (loads SEED, or 1 if SEED is 0)
//   en         : advance one step per cycle when high
//   state      : low OUT_W bits of the shift register
module puzzle_lfsr
  import puzzle_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED  = 8'hA5,
  parameter int unsigned       OUT_W = LFSR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [OUT_W-1:0] state
);

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [LFSR_W-1:0] SAFE_SEED = (SEED == '0) ? LFSR_W'(1) : SEED;

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  logic              fb;

  // Next-state: shift left, feedback into bit 0.
  always_comb begin
    fb     = ^(lfsr_q & LFSR_TAPS);
    lfsr_d = lfsr_q;
    if (en) begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], fb};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SAFE_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/puzzle_select.sv
// Picks the puzzle-set index for the lookup table: on each new-game request it
// deals a pseudo-random allowed index, never repeating one until the deck of
// allowed indices is exhausted, and holds it with puzzle_valid until the next request.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   new_req      : new-game request level; rising edge starts a draw
//   index        : selected puzzle index (registered)
//   puzzle_valid : index is stable and usable (registered)
//   puzzles_left : allowed indices not yet dealt in the current deck (registered)
//   deck_wrap    : one-cycle pulse when the deck is recycled (registered)
module puzzle_select
  import puzzle_pkg::*;
#(
  parameter logic [LFSR_W-1:0]   LFSR_SEED    = 8'hA5,
  parameter logic [NUM_SETS-1:0] EXCLUDE_MASK = 16'h4000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             new_req,
  output logic [IDX_W-1:0] index,
  output logic             puzzle_valid,
  output logic [CNT_W-1:0] puzzles_left,
  output logic             deck_wrap
);

  localparam logic [CNT_W-1:0] ALLOWED = popcount16(~EXCLUDE_MASK);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic                valid_q, valid_d;
  logic [CNT_W-1:0]    left_q, left_d;
  logic                wrap_q, wrap_d;
  logic [NUM_SETS-1:0] used_q, used_d;
  logic                req_q;

  logic [IDX_W-1:0]    cand;
  logic                req_rise;
  logic                hit;
  logic                enter_search;

  // Only the low nibble is needed as a candidate index.
  puzzle_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (IDX_W)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .state (cand)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    valid_d  = valid_q;
    left_d   = left_q;
    used_d   = used_q;
    wrap_d   = 1'b0;

    req_rise     = new_req & ~req_q;
    hit          = ~used_q[cand] & ~EXCLUDE_MASK[cand];
    enter_search = 1'b0;

    unique case (state_q)
      IDLE: begin
        enter_search = req_rise;
      end
      SEARCH: begin
        // Requests are ignored here; a hit always wins.
        if (hit) begin
          index_d       = cand;
          used_d[cand]  = 1'b1;
          left_d        = left_q - CNT_W'(left_q != '0);
          valid_d       = 1'b1;
          state_d       = PRESENT;
        end
      end
      PRESENT: begin
        enter_search = req_rise;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (enter_search) begin
      state_d = SEARCH;
      valid_d = 1'b0;
      // Recycle the deck but keep the just-shown index out of it, unless it
      // is the only allowed index, in which case it must be re-issued.
      if (left_q == '0) begin
        used_d = (ALLOWED > CNT_W'(1)) ? (NUM_SETS'(1) << index_q) : '0;
        left_d = ALLOWED - CNT_W'(1);
        wrap_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      index_q <= '0;
      valid_q <= 1'b0;
      left_q  <= ALLOWED;
      wrap_q  <= 1'b0;
      used_q  <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      valid_q <= valid_d;
      left_q  <= left_d;
      wrap_q  <= wrap_d;
      used_q  <= used_d;
      req_q   <= new_req;
    end
  end

  assign index        = index_q;
  assign puzzle_valid = valid_q;
  assign puzzles_left = left_q;
  assign deck_wrap    = wrap_q;

endmodule

// File: tb/tb_puzzle_select.sv
// Self-checking bench for puzzle_select: a deck model (dealt flags, remaining
// count) plus an LFSR sequence model predict the exact index and latency of
// every draw, with random idle gaps between requests.
module tb_puzzle_select;

  localparam logic [15:0] EXCL = 16'h4000;
  localparam logic [7:0]  SEED = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       new_req = 1'b0;
  logic [3:0] index;
  logic       puzzle_valid;
  logic [4:0] puzzles_left;
  logic       deck_wrap;

  int vectors = 0;
  int miscompares = 0;

  bit         dealt [16];
  int         left_m;
  int         allowed_m;
  logic [3:0] last_idx;
  logic [7:0] m_lfsr;

  puzzle_select #(
    .LFSR_SEED    (SEED),
    .EXCLUDE_MASK (EXCL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .new_req      (new_req),
    .index        (index),
    .puzzle_valid (puzzle_valid),
    .puzzles_left (puzzles_left),
    .deck_wrap    (deck_wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Sequence position of the free-running random source.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= SEED;
    else        m_lfsr <= step(m_lfsr);
  end

  function automatic bit is_free(input logic [3:0] n);
    logic [15:0] ex;
    ex = EXCL;
    return !dealt[n] && !ex[n];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) dealt[i] = 1'b0;
    left_m   = allowed_m;
    last_idx = 4'd0;
  endtask

  // One request/draw; hold keeps new_req high, pulse re-requests during SEARCH.
  task automatic do_draw(input bit hold, input bit pulse, input string tag);
    logic [7:0] v;
    logic [3:0] exp_idx;
    logic [15:0] ex;
    int  k;
    int  n;
    int  wraps;
    bit  wrap_exp;
    ex = EXCL;
    repeat (1 + $urandom_range(0, 6)) @(negedge clk);
    wrap_exp = (left_m == 0);
    if (wrap_exp) begin
      for (int i = 0; i < 16; i++) dealt[i] = 1'b0;
      if (allowed_m > 1) dealt[last_idx] = 1'b1;
      left_m = allowed_m - 1;
    end
    new_req = 1'b1;
    @(negedge clk);
    if (!hold) new_req = 1'b0;
    check({tag, " wrap pulse"}, 32'(deck_wrap), 32'(wrap_exp));
    check({tag, " valid drops"}, 32'(puzzle_valid), 32'd0);
    v = m_lfsr;
    k = 0;
    while (!is_free(v[3:0]) && k < 300) begin
      v = step(v);
      k++;
    end
    exp_idx = v[3:0];
    n = 0;
    wraps = 0;
    while (puzzle_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
      wraps += int'(deck_wrap);
      if (pulse && n == 1 && k >= 1) new_req = 1'b1;
      else if (!hold) new_req = 1'b0;
    end
    check({tag, " latency"}, 32'(n), 32'(k + 1));
    check({tag, " latency range"}, 32'((n + 1 >= 2) && (n + 1 <= 256)), 32'd1);
    check({tag, " index"}, 32'(index), 32'(exp_idx));
    check({tag, " not excluded"}, 32'(ex[index]), 32'd0);
    check({tag, " left"}, 32'(puzzles_left), 32'(left_m - 1));
    check({tag, " extra wrap"}, 32'(wraps), 32'd0);
    dealt[exp_idx] = 1'b1;
    left_m--;
    last_idx = exp_idx;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] prev_idx;
    logic [3:0] hold_idx;
    logic [4:0] hold_left;
    bit         stable;
    logic [15:0] ex;
    ex = EXCL;
    allowed_m = 0;
    for (int i = 0; i < 16; i++) allowed_m += int'(!ex[i]);
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst index", 32'(index), 32'd0);
    check("rst valid", 32'(puzzle_valid), 32'd0);
    check("rst wrap", 32'(deck_wrap), 32'd0);
    check("rst left", 32'(puzzles_left), 32'd15);
    rst_n = 1'b1;

    // First draw from IDLE with new_req held high: exactly one draw
    do_draw(1'b1, 1'b0, "hold");
    stable    = 1'b1;
    hold_idx  = index;
    hold_left = puzzles_left;
    repeat (50) begin
      @(negedge clk);
      if (puzzle_valid !== 1'b1 || index !== hold_idx || puzzles_left !== hold_left) stable = 1'b0;
    end
    check("hold stable", 32'(stable), 32'd1);
    new_req = 1'b0;

    // Remaining 14 draws of the first deck
    for (int d = 0; d < 14; d++) do_draw(1'b0, 1'b0, "deal");
    check("deck empty", 32'(puzzles_left), 32'd0);

    // 16th draw recycles the deck
    prev_idx = index;
    do_draw(1'b0, 1'b0, "wrap draw");
    check("no back-to-back repeat", 32'(index != prev_idx), 32'd1);

    // Requests during SEARCH are ignored
    for (int d = 0; d < 3; d++) begin
      do_draw(1'b0, 1'b1, "search pulse");
      new_req   = 1'b0;
      hold_idx  = index;
      hold_left = puzzles_left;
      stable    = 1'b1;
      repeat (4) begin
        @(negedge clk);
        if (puzzle_valid !== 1'b1 || index !== hold_idx || puzzles_left !== hold_left) stable = 1'b0;
      end
      check("one index presented", 32'(stable), 32'd1);
    end

    // Async reset in the middle of SEARCH
    @(negedge clk);
    new_req = 1'b1;
    @(negedge clk);
    new_req = 1'b0;
    check("mid search valid", 32'(puzzle_valid), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async rst index", 32'(index), 32'd0);
    check("async rst valid", 32'(puzzle_valid), 32'd0);
    check("async rst wrap", 32'(deck_wrap), 32'd0);
    check("async rst left", 32'(puzzles_left), 32'd15);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    do_draw(1'b0, 1'b0, "post reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
